// File: rtl/m_axil_arb_pkg.sv
// ----------------------------------------------------------------------------
// m_axil_arb_pkg
// Shared types and constants for the AXI-Lite request arbiter:
//   arb_state_e   - arbiter FSM state encoding
//   RESP_OKAY     - AXI response OKAY (2'b00)
//   RESP_SLVERR   - AXI response SLVERR (2'b10)
//   PROT_DEFAULT  - AxPROT driven on every transaction (unprivileged, secure, data)
// ----------------------------------------------------------------------------
package m_axil_arb_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        WB   = 3'd2,
        RD   = 3'd3,
        RR   = 3'd4,
        RSP  = 3'd5
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/m_axil_rr_arbiter.sv
// ----------------------------------------------------------------------------
// m_axil_rr_arbiter
// Combinational grant pick: scans the request vector starting at start_i and
// wrapping modulo NUM_REQ, returning the first requester found.
// Ports:
//   req_i        in   NUM_REQ  pending request vector
//   start_i      in   IDX_W    index to begin the scan at
//   grant_vld_o  out  1        at least one request pending
//   grant_idx_o  out  IDX_W    chosen requester (0 when none pending)
// ----------------------------------------------------------------------------
module m_axil_rr_arbiter
    import m_axil_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   start_i,
    output logic               grant_vld_o,
    output logic [IDX_W-1:0]   grant_idx_o
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        grant_vld_o = 1'b0;
        grant_idx_o = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand     = (int'(start_i) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!grant_vld_o && req_i[cand_idx]) begin
                grant_vld_o = 1'b1;
                grant_idx_o = cand_idx;
            end
        end
    end

endmodule

// File: rtl/m_axil_arbiter.sv
// ----------------------------------------------------------------------------
// m_axil_arbiter
// Arbitrates NUM_REQ simple requesters onto one AXI-Lite master port, one
// transaction in flight at a time.
//
// state | meaning
// IDLE  | waiting for a request; grant, pulse req_ready, latch request
// WR    | AW and W offered; each drops on its own handshake
// WB    | waiting for write response
// RD    | AR offered until accepted
// RR    | waiting for read data
// RSP   | one-cycle rsp_valid to owning requester, update last grant
//
// Ports:
//   clk, rst (async, active high)
//   req_valid/req_write/req_addr/req_wdata/req_wstrb  in  packed per requester
//   req_ready  out  one-cycle accept pulse;  rsp_valid out one-cycle done pulse
//   rsp_rdata/rsp_resp  out  shared response, nonzero only with rsp_valid
//   m_axil_aw*/w*/b*/ar*/r*  AXI-Lite master
// Build option: M_AXIL_ARB_FIXED_PRIO_EN selects fixed lowest-index priority
// instead of round-robin.
// ----------------------------------------------------------------------------
module m_axil_arbiter
    import m_axil_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0]   req_wdata,
    input  logic [NUM_REQ*4-1:0]    req_wstrb,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [31:0]             rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic [ADDR_W-1:0]       m_axil_awaddr,
    output logic [2:0]              m_axil_awprot,
    output logic                    m_axil_awvalid,
    input  logic                    m_axil_awready,
    output logic [31:0]             m_axil_wdata,
    output logic [3:0]              m_axil_wstrb,
    output logic                    m_axil_wvalid,
    input  logic                    m_axil_wready,
    input  logic [1:0]              m_axil_bresp,
    input  logic                    m_axil_bvalid,
    output logic                    m_axil_bready,
    output logic [ADDR_W-1:0]       m_axil_araddr,
    output logic [2:0]              m_axil_arprot,
    output logic                    m_axil_arvalid,
    input  logic                    m_axil_arready,
    input  logic [31:0]             m_axil_rdata,
    input  logic [1:0]              m_axil_rresp,
    input  logic                    m_axil_rvalid,
    output logic                    m_axil_rready
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       resp_q, resp_d;

    logic             gnt_vld;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] start_ptr;

    logic             sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]      sel_wdata;
    logic [3:0]       sel_wstrb;

`ifdef M_AXIL_ARB_FIXED_PRIO_EN
    assign start_ptr = '0;
`else
    logic [IDX_W-1:0] last_grant_q, last_grant_d;

    assign last_grant_d = (state_q == RSP) ? grant_q : last_grant_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_grant_q <= IDX_W'(NUM_REQ - 1);
        else     last_grant_q <= last_grant_d;
    end

    assign start_ptr = (last_grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : last_grant_q + 1'b1;
`endif

    m_axil_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i       (req_valid),
        .start_i     (start_ptr),
        .grant_vld_o (gnt_vld),
        .grant_idx_o (gnt_idx)
    );

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*32 +: 32];
                sel_wstrb = req_wstrb[i*4 +: 4];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    grant_d   = gnt_idx;
                    addr_d    = sel_addr;
                    wdata_d   = sel_wdata;
                    wstrb_d   = sel_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = sel_write ? WR : RD;
                end
            end
            WR: begin
                if (m_axil_awvalid && m_axil_awready) aw_done_d = 1'b1;
                if (m_axil_wvalid && m_axil_wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)            state_d   = WB;
            end
            WB: begin
                if (m_axil_bvalid) begin
                    resp_d  = m_axil_bresp;
                    rdata_d = '0;
                    state_d = RSP;
                end
            end
            RD: begin
                if (m_axil_arready) state_d = RR;
            end
            RR: begin
                if (m_axil_rvalid) begin
                    resp_d  = m_axil_rresp;
                    rdata_d = m_axil_rdata;
                    state_d = RSP;
                end
            end
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    // req_ready is combinational so the grant lands in the same cycle the
    // request is seen; rst gates it so reset silences it immediately.
    assign req_ready = (state_q == IDLE && gnt_vld && !rst) ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign rsp_valid = (state_q == RSP) ? (NUM_REQ'(1) << grant_q) : '0;
    assign rsp_rdata = (state_q == RSP) ? rdata_q : '0;
    assign rsp_resp  = (state_q == RSP) ? resp_q  : '0;

    assign m_axil_awaddr  = addr_q;
    assign m_axil_awprot  = PROT_DEFAULT;
    assign m_axil_awvalid = (state_q == WR) && !aw_done_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_wvalid  = (state_q == WR) && !w_done_q;
    assign m_axil_bready  = (state_q == WB);
    assign m_axil_araddr  = addr_q;
    assign m_axil_arprot  = PROT_DEFAULT;
    assign m_axil_arvalid = (state_q == RD);
    assign m_axil_rready  = (state_q == RR);

endmodule

// File: tb/tb_m_axil_arbiter.sv
module tb_m_axil_arbiter;
    import m_axil_arb_pkg::*;

    localparam int NR = 2;
    localparam int AW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_write, req_ready, rsp_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*32-1:0]  req_wdata;
    logic [NR*4-1:0]   req_wstrb;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_resp;
    logic [AW-1:0]     m_awaddr, m_araddr;
    logic [2:0]        m_awprot, m_arprot;
    logic              m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic              m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0]       m_wdata, m_rdata;
    logic [3:0]        m_wstrb;
    logic [1:0]        m_bresp, m_rresp;

    int checks = 0;
    int errors = 0;

    // slave configuration (written by the main sequence only)
    int         aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = 32'h0;

    // slave state (written by the slave process only)
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    bit aw_got, w_got, ar_got;
    int n_aw = 0, n_w = 0, n_b = 0, n_r = 0;

    always #5 clk = ~clk;

    m_axil_arbiter #(.NUM_REQ(NR), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axil_awaddr(m_awaddr), .m_axil_awprot(m_awprot), .m_axil_awvalid(m_awvalid),
        .m_axil_awready(m_awready), .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb),
        .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready), .m_axil_bresp(m_bresp),
        .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready), .m_axil_araddr(m_araddr),
        .m_axil_arprot(m_arprot), .m_axil_arvalid(m_arvalid), .m_axil_arready(m_arready),
        .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp), .m_axil_rvalid(m_rvalid),
        .m_axil_rready(m_rready)
    );

    task automatic slave_clear();
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
    endtask

    // Slave model: drives at the falling edge and books the handshakes that
    // will occur at the following rising edge.
    initial begin : slave
        slave_clear();
        forever begin
            @(negedge clk);
            if (rst) begin
                slave_clear();
            end else begin
                m_awready = m_awvalid && !aw_got && (aw_wait >= aw_lat);
                m_wready  = m_wvalid && !w_got && (w_wait >= w_lat);
                m_bvalid  = aw_got && w_got && (b_wait >= b_lat);
                m_bresp   = m_bvalid ? bresp_cfg : 2'b00;
                m_arready = m_arvalid && !ar_got && (ar_wait >= ar_lat);
                m_rvalid  = ar_got && (r_wait >= r_lat);
                m_rdata   = m_rvalid ? rdata_cfg : 32'h0;
                m_rresp   = m_rvalid ? rresp_cfg : 2'b00;
                if (m_bvalid && m_bready) begin
                    aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0; b_wait = 0; n_b++;
                end else if (aw_got && w_got) b_wait++;
                if (m_awvalid && m_awready) begin aw_got = 1; n_aw++; end
                else if (m_awvalid) aw_wait++;
                if (m_wvalid && m_wready) begin w_got = 1; n_w++; end
                else if (m_wvalid) w_wait++;
                if (m_rvalid && m_rready) begin ar_got = 0; ar_wait = 0; r_wait = 0; n_r++; end
                else if (ar_got) r_wait++;
                if (m_arvalid && m_arready) ar_got = 1;
                else if (m_arvalid) ar_wait++;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        req_valid = 2'b11; req_write = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
        checks++;
        if (rsp_valid !== 2'b00 || rsp_rdata !== 32'h0 || rsp_resp !== 2'b00) begin
            errors++; $display("FAIL reset_rsp got v=%b d=%h r=%b exp 0", rsp_valid, rsp_rdata, rsp_resp);
        end
        checks++;
        if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 5'b0) begin
            errors++; $display("FAIL reset_axi_ctrl got %b exp 00000", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
        end
        checks++;
        if (m_awaddr !== 32'h0 || m_wdata !== 32'h0 || m_wstrb !== 4'h0 || m_awprot !== 3'b000) begin
            errors++; $display("FAIL reset_axi_data got a=%h d=%h s=%h p=%b exp 0", m_awaddr, m_wdata, m_wstrb, m_awprot);
        end
        req_valid = 2'b00; req_write = 2'b00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        @(negedge clk);
        req_valid = 2'b01; req_write = 2'b01;
        req_addr[31:0] = 32'h10; req_wdata[31:0] = 32'hDEADBEEF; req_wstrb[3:0] = 4'hF;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL wr_req_ready got %b exp 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        checks++;
        if (m_awvalid !== 1'b1 || m_wvalid !== 1'b1) begin
            errors++; $display("FAIL wr_issue got aw=%b w=%b exp 1 1", m_awvalid, m_wvalid);
        end
        checks++;
        if (m_awaddr !== 32'h10 || m_wdata !== 32'hDEADBEEF || m_wstrb !== 4'hF || m_awprot !== 3'b000) begin
            errors++; $display("FAIL wr_payload got a=%h d=%h s=%h p=%b exp 10 deadbeef f 000", m_awaddr, m_wdata, m_wstrb, m_awprot);
        end
        @(negedge clk);
        #1;
        checks++;
        if (m_bready !== 1'b1 || m_awvalid !== 1'b0 || m_wvalid !== 1'b0 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL wr_wb got br=%b aw=%b w=%b rv=%b exp 1 0 0 00", m_bready, m_awvalid, m_wvalid, rsp_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_resp !== RESP_OKAY || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL wr_rsp got v=%b r=%b d=%h exp 01 00 0", rsp_valid, rsp_resp, rsp_rdata);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 2'b00) begin errors++; $display("FAIL wr_rsp_pulse got %b exp 00", rsp_valid); end
    endtask

    task automatic test_round_robin();
        int exp_g[4];
        int ng = 0, nr = 0, cur = 0;
        logic [31:0] exp_addr;
`ifdef M_AXIL_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0};
`else
        exp_g = '{0, 1, 0, 1};
`endif
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        req_write = 2'b11;
        req_addr  = {32'h200, 32'h100};
        req_wdata = {32'h2222_2222, 32'h1111_1111};
        req_wstrb = 8'hFF;
        req_valid = 2'b11;
        for (int k = 0; k < 40 && nr < 4; k++) begin
            #1;
            if (req_ready !== 2'b00 && ng < 4) begin
                checks++;
                if (req_ready !== (2'b01 << exp_g[ng])) begin
                    errors++; $display("FAIL rr_grant%0d got %b exp %b", ng, req_ready, 2'b01 << exp_g[ng]);
                end
                cur = exp_g[ng];
                ng++;
            end
            if (m_awvalid) begin
                exp_addr = (cur == 0) ? 32'h100 : 32'h200;
                checks++;
                if (m_awaddr !== exp_addr) begin errors++; $display("FAIL rr_awaddr got %h exp %h", m_awaddr, exp_addr); end
            end
            if (rsp_valid !== 2'b00) begin
                checks++;
                if (rsp_valid !== (2'b01 << exp_g[nr])) begin
                    errors++; $display("FAIL rr_rsp%0d got %b exp %b", nr, rsp_valid, 2'b01 << exp_g[nr]);
                end
                nr++;
            end
            if (nr < 4) @(negedge clk);
        end
        req_valid = 2'b00;
        checks++;
        if (ng != 4 || nr != 4) begin errors++; $display("FAIL rr_count got grants=%0d rsps=%0d exp 4 4", ng, nr); end
    endtask

    task automatic test_w_before_aw();
        int b0, aw0, w0, nrsp;
        aw_lat = 3;
        b0 = n_b; aw0 = n_aw; w0 = n_w; nrsp = 0;
        @(negedge clk);
        req_valid = 2'b10; req_write = 2'b10;
        req_addr[63:32] = 32'h44; req_wdata[63:32] = 32'hCAFEF00D; req_wstrb[7:4] = 4'h3;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL wa_req_ready got %b exp 10", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        checks++;
        if (m_awvalid !== 1'b1 || m_wvalid !== 1'b1) begin
            errors++; $display("FAIL wa_issue got aw=%b w=%b exp 1 1", m_awvalid, m_wvalid);
        end
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (m_awvalid !== 1'b1 || m_wvalid !== 1'b0 || m_awaddr !== 32'h44) begin
                errors++; $display("FAIL wa_hold_c%0d got aw=%b w=%b a=%h exp 1 0 44", c, m_awvalid, m_wvalid, m_awaddr);
            end
        end
        for (int c = 5; c <= 12; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid !== 2'b00) begin
                nrsp++;
                checks++;
                if (c != 6 || rsp_valid !== 2'b10) begin
                    errors++; $display("FAIL wa_rsp got v=%b at cycle %0d exp 10 at 6", rsp_valid, c);
                end
            end
        end
        checks++;
        if (nrsp != 1 || n_b - b0 != 1 || n_aw - aw0 != 1 || n_w - w0 != 1) begin
            errors++; $display("FAIL wa_counts got rsp=%0d b=%0d aw=%0d w=%0d exp 1 1 1 1", nrsp, n_b - b0, n_aw - aw0, n_w - w0);
        end
        aw_lat = 0;
    endtask

    task automatic test_read();
        int nrsp = 0;
        r_lat = 5; rdata_cfg = 32'h12345678; rresp_cfg = 2'b10;
        @(negedge clk);
        req_valid = 2'b01; req_write = 2'b00; req_addr[31:0] = 32'h20;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL rd_req_ready got %b exp 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        checks++;
        if (m_arvalid !== 1'b1 || m_araddr !== 32'h20 || m_arprot !== 3'b000 || m_awvalid !== 1'b0) begin
            errors++; $display("FAIL rd_issue got ar=%b a=%h p=%b aw=%b exp 1 20 000 0", m_arvalid, m_araddr, m_arprot, m_awvalid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (m_rready !== 1'b1 || m_arvalid !== 1'b0) begin
            errors++; $display("FAIL rd_rr got rr=%b ar=%b exp 1 0", m_rready, m_arvalid);
        end
        for (int c = 3; c <= 10; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid !== 2'b00) begin
                nrsp++;
                checks++;
                if (c != 8 || rsp_valid !== 2'b01 || rsp_rdata !== 32'h12345678 || rsp_resp !== 2'b10) begin
                    errors++; $display("FAIL rd_rsp got v=%b d=%h r=%b cyc=%0d exp 01 12345678 10 8", rsp_valid, rsp_rdata, rsp_resp, c);
                end
            end
        end
        checks++;
        if (nrsp != 1) begin errors++; $display("FAIL rd_rsp_count got %0d exp 1", nrsp); end
        r_lat = 0; rdata_cfg = 32'h0; rresp_cfg = 2'b00;
    endtask

    task automatic test_reset_in_wb();
        int nrsp = 0;
        b_lat = 3;
        @(negedge clk);
        req_valid = 2'b10; req_write = 2'b10; req_addr[63:32] = 32'h88;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL rwb_req_ready got %b exp 10", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        checks++;
        if (m_bready !== 1'b1) begin errors++; $display("FAIL rwb_in_wb got bready=%b exp 1", m_bready); end
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 9'b0 ||
            rsp_rdata !== 32'h0 || m_awaddr !== 32'h0) begin
            errors++; $display("FAIL rwb_outputs got ctl=%b d=%h a=%h exp 0",
                {req_ready, rsp_valid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, rsp_rdata, m_awaddr);
        end
        b_lat = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 2) rst = 1'b0;
            #1;
            if (rsp_valid !== 2'b00) nrsp++;
        end
        checks++;
        if (nrsp != 0) begin errors++; $display("FAIL rwb_no_rsp got %0d pulses exp 0", nrsp); end
        @(negedge clk);
        req_valid = 2'b11; req_write = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL rwb_regrant got %b exp 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        nrsp = 0;
        for (int c = 0; c < 12 && nrsp == 0; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid !== 2'b00) nrsp++;
        end
        checks++;
        if (nrsp != 1 || rsp_valid !== 2'b01) begin
            errors++; $display("FAIL rwb_after got pulses=%0d v=%b exp 1 01", nrsp, rsp_valid);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_w_before_aw();
        test_read();
        test_reset_in_wb();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
